// File: rtl/scanchain_pkg.sv
// Shared widths and request packing for the scan-chain write queue.
// Entry layout, MSB first: {reset flag, addr, payload}.
package scanchain_pkg;

  localparam int SC_ADDR_BITS    = 12;
  localparam int SC_PAYLOAD_BITS = 169;
  localparam int SC_ENTRY_BITS   = 1 + SC_ADDR_BITS + SC_PAYLOAD_BITS;

  typedef struct packed {
    logic                       rst;
    logic [SC_ADDR_BITS-1:0]    addr;
    logic [SC_PAYLOAD_BITS-1:0] payload;
  } sc_req_t;

  function automatic logic [SC_ENTRY_BITS-1:0] sc_pack(
    input logic                       rst,
    input logic [SC_ADDR_BITS-1:0]    addr,
    input logic [SC_PAYLOAD_BITS-1:0] payload
  );
    return {rst, addr, payload};
  endfunction

  function automatic sc_req_t sc_unpack(input logic [SC_ENTRY_BITS-1:0] entry);
    return sc_req_t'(entry);
  endfunction

endpackage

// File: rtl/scanchain_queue_mem.sv
// Register-array storage for the write queue: one write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy in the parent masks stale entries.
module scanchain_queue_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/scanchain_write_queue.sv
// Elastic, order-preserving FIFO of scan-chain write requests between the UART client and writer.
// Define SCANCHAIN_QUEUE_BYPASS_EN for an empty-queue combinational fall-through path.
module scanchain_write_queue
  import scanchain_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ADDR_BITS    = SC_ADDR_BITS,
  parameter int PAYLOAD_BITS = SC_PAYLOAD_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_BITS-1:0]       in_addr,
  input  logic [PAYLOAD_BITS-1:0]    in_payload,
  input  logic                       in_reset,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_BITS-1:0]       out_addr,
  output logic [PAYLOAD_BITS-1:0]    out_payload,
  output logic                       out_reset,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] high_water
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
  // in_ready depends only on registered state and reset, never on out_ready.
  logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]         r_count, r_high_water, w_count_next;
  logic                     w_full, w_empty, w_push, w_pop, w_store, w_take;
  logic [SC_ENTRY_BITS-1:0] w_in_entry, w_rd_entry, w_out_entry;
  sc_req_t                  w_head;

  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  assign w_in_entry = sc_pack(in_reset, in_addr, in_payload);

  assign in_ready = !reset && !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;

`ifdef SCANCHAIN_QUEUE_BYPASS_EN
  // Empty queue presents the incoming request directly; a same-cycle pop consumes it unstored.
  assign out_valid   = !reset && (!w_empty || in_valid);
  assign w_out_entry = !out_valid ? '0 : (w_empty ? w_in_entry : w_rd_entry);
  assign w_store     = w_push && !(w_empty && out_ready);
  assign w_take      = w_pop && !w_empty;
`else
  assign out_valid   = !reset && !w_empty;
  assign w_out_entry = out_valid ? w_rd_entry : '0;
  assign w_store     = w_push;
  assign w_take      = w_pop;
`endif

  assign w_head      = sc_unpack(w_out_entry);
  assign out_reset   = w_head.rst;
  assign out_addr    = w_head.addr;
  assign out_payload = w_head.payload;

  always_comb begin
    w_count_next = r_count;
    case ({w_store, w_take})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_high_water <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_take)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      if (w_count_next > r_high_water) r_high_water <= w_count_next;
    end
  end

  assign count      = r_count;
  assign high_water = r_high_water;

  scanchain_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (SC_ENTRY_BITS)
  ) u_mem (
    .i_clk     (clk),
    .i_wr_en   (w_store),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_in_entry),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_entry)
  );

endmodule

// File: tb/tb_scanchain_write_queue.sv
// Directed bench for scanchain_write_queue with a reference queue of expected entries.
// Honours SCANCHAIN_QUEUE_BYPASS_EN when the design is built with it.
module tb_scanchain_write_queue;
  import scanchain_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [SC_ADDR_BITS-1:0]    in_addr = '0;
  logic [SC_PAYLOAD_BITS-1:0] in_payload = '0;
  logic                       in_reset = 1'b0;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [SC_ADDR_BITS-1:0]    out_addr;
  logic [SC_PAYLOAD_BITS-1:0] out_payload;
  logic                       out_reset;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           high_water;

  int n_tests = 0;
  int n_fail  = 0;
  logic [SC_ENTRY_BITS-1:0] exp_q[$];
  int m_hw = 0;

  scanchain_write_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_payload  (in_payload),
    .in_reset    (in_reset),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_payload (out_payload),
    .out_reset   (out_reset),
    .count       (count),
    .high_water  (high_water)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SC_PAYLOAD_BITS-1:0] pay(input logic [SC_ADDR_BITS-1:0] a);
    logic [SC_PAYLOAD_BITS-1:0] p;
    p = '0;
    p[SC_ADDR_BITS-1:0] = a;
    p[SC_PAYLOAD_BITS-1 -: SC_ADDR_BITS] = ~a;
    return p;
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, then check registered state after the edge.
  task automatic cycle(input logic iv, input logic [SC_ADDR_BITS-1:0] a, input logic rf,
                       input logic ordy);
    logic                     exp_ir, exp_ov, push, pop;
    logic [SC_ENTRY_BITS-1:0] in_e, exp_head;
    int                       cnt;
    sc_req_t                  h;
    in_valid   = iv;
    in_addr    = a;
    in_payload = pay(a);
    in_reset   = rf;
    out_ready  = ordy;
    in_e       = {rf, a, pay(a)};
    cnt        = exp_q.size();
    #1;
    exp_ir = (cnt != DEPTH);
`ifdef SCANCHAIN_QUEUE_BYPASS_EN
    exp_ov   = (cnt != 0) || iv;
    exp_head = (cnt != 0) ? exp_q[0] : (iv ? in_e : '0);
`else
    exp_ov   = (cnt != 0);
    exp_head = (cnt != 0) ? exp_q[0] : '0;
`endif
    h = sc_req_t'(exp_head);
    check("in_ready", 256'(in_ready), 256'(exp_ir));
    check("out_valid", 256'(out_valid), 256'(exp_ov));
    check("out_addr", 256'(out_addr), 256'(h.addr));
    check("out_payload", 256'(out_payload), 256'(h.payload));
    check("out_reset", 256'(out_reset), 256'(h.rst));
    push = iv && exp_ir;
    pop  = exp_ov && ordy;
    @(posedge clk);
    #1;
    if (pop && cnt != 0) void'(exp_q.pop_front());
    if (push && !(cnt == 0 && pop)) exp_q.push_back(in_e);
    if (exp_q.size() > m_hw) m_hw = exp_q.size();
    check("count", 256'(count), 256'(exp_q.size()));
    check("high_water", 256'(high_water), 256'(m_hw));
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_addr", 256'(out_addr), 256'(0));
    check("rst_out_payload", 256'(out_payload), 256'(0));
    @(posedge clk);
    #1;
    exp_q.delete();
    m_hw     = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 256'(in_ready), 256'(1));
    check("post_rst_out_valid", 256'(out_valid), 256'(0));
    check("post_rst_count", 256'(count), 256'(0));
    check("post_rst_high_water", 256'(high_water), 256'(0));
    check("post_rst_out_addr", 256'(out_addr), 256'(0));
  endtask

  initial begin
    @(posedge clk);
    reset_dut();
    cycle(1'b0, 12'h000, 1'b0, 1'b0);

    // Three entries held back, then drained in order.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 12'(i), 1'b0, 1'b0);
    check("three_count", 256'(count), 256'(3));
    check("three_head", 256'(out_addr), 256'(12'h001));
    for (int i = 0; i < 3; i++) cycle(1'b0, 12'h000, 1'b0, 1'b1);
    cycle(1'b0, 12'h000, 1'b0, 1'b0);

    // Fill, refuse a held 9th push, full push+pop pops only, then the held push lands.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 12'(12'h020 + i), 1'b0, 1'b0);
    check("full_count", 256'(count), 256'(8));
    check("full_high_water", 256'(high_water), 256'(8));
    cycle(1'b1, 12'h028, 1'b0, 1'b0);
    cycle(1'b1, 12'h028, 1'b0, 1'b0);
    cycle(1'b1, 12'h028, 1'b0, 1'b1);
    check("full_pushpop_count", 256'(count), 256'(7));
    cycle(1'b1, 12'h028, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 12'h000, 1'b0, 1'b1);
    check("drained_count", 256'(count), 256'(0));

    // A reset-command entry sits between 0x010 and 0x011.
    cycle(1'b1, 12'h010, 1'b0, 1'b0);
    cycle(1'b1, 12'h0FF, 1'b1, 1'b0);
    cycle(1'b1, 12'h011, 1'b0, 1'b0);
    cycle(1'b0, 12'h000, 1'b0, 1'b1);
    check("mid_is_reset", 256'(out_reset), 256'(1));
    cycle(1'b0, 12'h000, 1'b0, 1'b1);
    cycle(1'b0, 12'h000, 1'b0, 1'b1);

    // Steady streaming at occupancy 2, wrapping the pointers.
    cycle(1'b1, 12'h100, 1'b0, 1'b0);
    cycle(1'b1, 12'h101, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 12'(12'h102 + i), 1'b0, 1'b1);
    check("stream_count", 256'(count), 256'(2));
    cycle(1'b0, 12'h000, 1'b0, 1'b1);
    cycle(1'b0, 12'h000, 1'b0, 1'b1);

    // Reset while five entries are queued.
    for (int i = 0; i < 5; i++) cycle(1'b1, 12'(12'h200 + i), 1'b0, 1'b0);
    check("five_count", 256'(count), 256'(5));
    reset_dut();

    // Empty queue with in_valid and out_ready together.
    cycle(1'b1, 12'h0AB, 1'b0, 1'b1);
    cycle(1'b0, 12'h000, 1'b0, 1'b1);
    cycle(1'b0, 12'h000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
